// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch redirect, mul/div and dmem wait.
// Stall/flush outputs are combinational; FSM, watchdog and stall counter are registered.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs1_addr_id_i,
    input  logic [4:0]  rs2_addr_id_i,
    input  logic        rs1_used_id_i,
    input  logic        rs2_used_id_i,
    input  logic [4:0]  rd_addr_ex_i,
    input  logic        mem_read_ex_i,
    input  logic        branch_taken_ex_i,
    input  logic        mc_start_ex_i,
    input  logic        mc_done_i,
    input  logic        dmem_req_mem_i,
    input  logic        dmem_ready_i,
    output logic        pc_stall_o,
    output logic        if_id_stall_o,
    output logic        if_id_flush_o,
    output logic        id_ex_stall_o,
    output logic        id_ex_flush_o,
    output logic        ex_mem_stall_o,
    output logic        ex_mem_flush_o,
    output logic        mem_wb_flush_o,
    output logic        mem_timeout_o,
    output logic [31:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MC_WAIT  = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam logic [16:0] TIMEOUT_LIM = 17'(MEM_TIMEOUT);

    state_t      state;
    state_t      state_nxt;
    logic        mc_pend;
    logic        mc_pend_nxt;
    logic [15:0] wait_cnt;

    logic mem_wait;
    logic load_use;
    logic mc_busy;
    logic rs1_hit;
    logic rs2_hit;

    assign mem_wait = dmem_req_mem_i & ~dmem_ready_i;
    assign rs1_hit  = rs1_used_id_i & (rs1_addr_id_i == rd_addr_ex_i);
    assign rs2_hit  = rs2_used_id_i & (rs2_addr_id_i == rd_addr_ex_i);
    assign load_use = mem_read_ex_i & (rd_addr_ex_i != 5'd0) & (rs1_hit | rs2_hit);
    // A done pulse in the same cycle as start (or while waiting) releases the stall at once.
    assign mc_busy  = ((state == MC_WAIT) | mc_pend | mc_start_ex_i) & ~mc_done_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            mc_pend <= 1'b0;
        end else begin
            state   <= state_nxt;
            mc_pend <= mc_pend_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        mc_pend_nxt    = mc_pend;
        pc_stall_o     = 1'b0;
        if_id_stall_o  = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_stall_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        ex_mem_stall_o = 1'b0;
        ex_mem_flush_o = 1'b0;
        mem_wb_flush_o = 1'b0;

        if (mem_wait) begin
            pc_stall_o     = 1'b1;
            if_id_stall_o  = 1'b1;
            id_ex_stall_o  = 1'b1;
            ex_mem_stall_o = 1'b1;
            mem_wb_flush_o = 1'b1;
        end else if (mc_busy) begin
            pc_stall_o     = 1'b1;
            if_id_stall_o  = 1'b1;
            id_ex_stall_o  = 1'b1;
            ex_mem_flush_o = 1'b1;
        end else if (branch_taken_ex_i) begin
            if_id_flush_o  = 1'b1;
            id_ex_flush_o  = 1'b1;
        end else if (load_use) begin
            pc_stall_o     = 1'b1;
            if_id_stall_o  = 1'b1;
            id_ex_flush_o  = 1'b1;
        end

        unique case (state)
            RUN: begin
                if (mem_wait) begin
                    state_nxt   = MEM_WAIT;
                    mc_pend_nxt = mc_start_ex_i & ~mc_done_i;
                end else if (mc_start_ex_i & ~mc_done_i) begin
                    state_nxt = MC_WAIT;
                end
            end
            MC_WAIT: begin
                if (mem_wait) begin
                    state_nxt   = MEM_WAIT;
                    mc_pend_nxt = ~mc_done_i;
                end else if (mc_done_i) begin
                    state_nxt = RUN;
                end
            end
            MEM_WAIT: begin
                if (!mem_wait) begin
                    state_nxt   = (mc_pend & ~mc_done_i) ? MC_WAIT : RUN;
                    mc_pend_nxt = 1'b0;
                end else if (mc_done_i) begin
                    mc_pend_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt   = RUN;
                mc_pend_nxt = 1'b0;
            end
        endcase

        // Pipeline registers must see inactive controls while reset is held.
        if (!rst_n) begin
            pc_stall_o     = 1'b0;
            if_id_stall_o  = 1'b0;
            if_id_flush_o  = 1'b0;
            id_ex_stall_o  = 1'b0;
            id_ex_flush_o  = 1'b0;
            ex_mem_stall_o = 1'b0;
            ex_mem_flush_o = 1'b0;
            mem_wb_flush_o = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt      <= 16'd0;
            mem_timeout_o <= 1'b0;
        end else if (mem_wait) begin
            if (wait_cnt != 16'hFFFF) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
            if (({1'b0, wait_cnt} + 17'd1) >= TIMEOUT_LIM) begin
                mem_timeout_o <= 1'b1;
            end
        end else begin
            wait_cnt <= 16'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_o <= 32'd0;
        end else if (pc_stall_o && (stall_cnt_o != 32'hFFFF_FFFF)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage RV32 pipeline. It drives the stall and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves load-use hazards, taken-branch redirects, multi-cycle EX operations (mul/div) and data-memory wait states. It also keeps a memory-wait watchdog and a saturating stall-cycle performance counter.

## Interface
Parameters:
- MEM_TIMEOUT, 255: consecutive memory-wait cycles after which `mem_timeout_o` is set (1..65535).

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- rs1_addr_id_i  in  5  rs1 of instruction in ID
- rs2_addr_id_i  in  5  rs2 of instruction in ID
- rs1_used_id_i  in  1  ID instruction reads rs1
- rs2_used_id_i  in  1  ID instruction reads rs2
- rd_addr_ex_i  in  5  destination of instruction in EX
- mem_read_ex_i  in  1  EX instruction is a load
- branch_taken_ex_i  in  1  EX resolved a taken branch/jump (redirect)
- mc_start_ex_i  in  1  EX holds a multi-cycle op (level, held while in EX)
- mc_done_i  in  1  multi-cycle unit result valid (1-cycle pulse)
- dmem_req_mem_i  in  1  MEM stage has an active data-memory access
- dmem_ready_i  in  1  data memory completes access this cycle
- pc_stall_o  out  1  hold PC
- if_id_stall_o  out  1  hold IF/ID
- if_id_flush_o  out  1  bubble IF/ID
- id_ex_stall_o  out  1  hold ID/EX
- id_ex_flush_o  out  1  bubble ID/EX
- ex_mem_stall_o  out  1  hold EX/MEM
- ex_mem_flush_o  out  1  bubble EX/MEM
- mem_wb_flush_o  out  1  bubble MEM/WB
- mem_timeout_o  out  1  sticky watchdog error
- stall_cnt_o  out  32  cycles with pc_stall_o=1, saturating

## Operation
- FSM states: RUN, MC_WAIT, MEM_WAIT. The register `mc_pend` records that a multi-cycle op is outstanding while in MEM_WAIT.
- mem_wait = dmem_req_mem_i & ~dmem_ready_i.
- load_use = mem_read_ex_i & (rd_addr_ex_i != 0) & ((rs1_used_id_i & rs1_addr_id_i == rd_addr_ex_i) | (rs2_used_id_i & rs2_addr_id_i == rd_addr_ex_i)).
- mc_busy = (state==MC_WAIT | mc_pend | mc_start_ex_i) & ~mc_done_i.
  - In RUN, mc_start_ex_i together with mc_done_i in the same cycle causes no stall.
- Output priority per cycle (first match wins; unlisted outputs are 0):
  1. mem_wait: pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_flush = 1. Branch and load-use are ignored; they re-evaluate after release.
  2. mc_busy: pc_stall, if_id_stall, id_ex_stall, ex_mem_flush = 1. The ID instruction is not bubbled.
  3. branch_taken_ex_i: if_id_flush, id_ex_flush = 1; PC not stalled. A coincident load-use is discarded.
  4. load_use: pc_stall, if_id_stall, id_ex_flush = 1.
- Transitions:
  - RUN→MEM_WAIT on mem_wait; mc_pend ← mc_start_ex_i & ~mc_done_i.
  - RUN→MC_WAIT on ~mem_wait & mc_start_ex_i & ~mc_done_i.
  - MC_WAIT→MEM_WAIT on mem_wait; mc_pend ← ~mc_done_i.
  - MC_WAIT→RUN on ~mem_wait & mc_done_i.
  - MEM_WAIT→(mc_pend & ~mc_done_i ? MC_WAIT : RUN) on ~mem_wait; mc_pend cleared.
  - While in MEM_WAIT, mc_done_i clears mc_pend.
- Watchdog: 16-bit wait counter increments each mem_wait cycle and clears on any non-mem_wait cycle. When the count reaches MEM_TIMEOUT, mem_timeout_o ← 1. It stays set until reset; the pipeline keeps stalling normally.
- stall_cnt_o increments when pc_stall_o=1 and holds at 32'hFFFF_FFFF.

## Timing
- Stall/flush outputs are combinational from the current state and inputs, for same-cycle use by the pipeline registers.
- mem_timeout_o, stall_cnt_o and the FSM are registered.
- Reset (async assert): state=RUN, mc_pend=0, wait counter=0, mem_timeout_o=0, stall_cnt_o=0. All stall/flush outputs are forced 0 while rst_n=0.
- Load-use costs exactly 1 bubble: one cycle of stall, then the load has left EX.
- A multi-cycle op whose mc_done_i arrives N cycles after the op enters EX costs N stall cycles. EX/MEM receives N bubbles.
- Reset mid-MC_WAIT or mid-MEM_WAIT returns to RUN immediately. No pending state survives.

## Test plan
- Load-use: mem_read_ex=1, rd_ex=5, rs1_id=5, rs1_used=1 for 1 cycle → pc_stall=if_id_stall=id_ex_flush=1 that cycle; stall_cnt_o=1 after. With rd_ex=0 → no stall.
- Branch+load-use coincident: branch_taken=1 with the load-use condition true → if_id_flush=id_ex_flush=1, pc_stall=0.
- Mul/div: mc_start held, mc_done pulses 4 cycles later → 4 cycles of pc/if_id/id_ex stall + ex_mem_flush; RUN on the 5th cycle. mc_start and mc_done in the same cycle → 0 stall.
- Memory wait during MC_WAIT: enter MC_WAIT, then dmem_req=1, ready=0 for 3 cycles → freeze-all plus mem_wb_flush. Then ready=1 → returns to MC_WAIT until mc_done.
- Watchdog: MEM_TIMEOUT=4, ready held 0 → mem_timeout_o rises after the 4th wait cycle and stays 1 after ready=1; a 3-cycle wait does not set it.
- Async reset in MEM_WAIT → all outputs 0 immediately; state RUN and stall_cnt_o=0 after release.
